// File: rtl/rng_word_serializer.sv
// rtl/rng_word_serializer.sv - filters an LFSR word bank, buffers accepted words in a FIFO, streams them one per handshake
module rng_word_serializer #(
   parameter int WORD_N     = 8,
   parameter int WORD_M     = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [WORD_M*WORD_N-1:0]      i_bank,
   output logic                          o_lfsr_enable,
   input  logic                          i_bound_en,
   input  logic [WORD_N-1:0]             i_bound,
   input  logic                          i_flush,
   output logic [WORD_N-1:0]             o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic [CNT_W-1:0]              o_drop_cnt
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int COUNT_W = PTR_W + 1;

   // A whole bank may only be taken when it is guaranteed to fit, whatever the filter decides.
   localparam logic [COUNT_W-1:0] CAP_LIMIT  = COUNT_W'(FIFO_DEPTH - WORD_M);
   localparam logic [COUNT_W-1:0] BANK_WORDS = COUNT_W'(WORD_M);

   // Pointers carry one extra wrap bit so that full and empty are distinguishable.
   logic [COUNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [COUNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [WORD_N-1:0]  mem_q [FIFO_DEPTH];

   logic [COUNT_W-1:0] count;
   logic [WORD_N-1:0]  bank_word [WORD_M];
   logic [WORD_M-1:0]  accept;
   logic [PTR_W-1:0]   slot_ofs [WORD_M];
   logic [PTR_W-1:0]   wr_addr [WORD_M];
   logic [COUNT_W-1:0] acc_cnt;
   logic [COUNT_W-1:0] rej_cnt;
   logic [CNT_W:0]     drop_sum;
   logic               filter_on;
   logic               cap;
   logic               pop;

   assign count = wr_ptr_q - rd_ptr_q;

   // Capture uses the registered occupancy only; a pop in the same cycle earns no extra room.
   // Held low during reset so the LFSR is never advanced while the FIFO is being cleared.
   assign cap = !i_rst && !i_flush && (count <= CAP_LIMIT);
   assign pop = o_valid && i_ready && !i_flush;

   assign filter_on = i_bound_en && (i_bound != '0);

   // Split the flat bank into words, word k at bits [k*WORD_N +: WORD_N].
   always_comb begin
      for (int k = 0; k < WORD_M; k++) begin
         bank_word[k] = i_bank[k*WORD_N +: WORD_N];
      end
   end

   // Accept/reject each word and pack survivors into consecutive slots in ascending k order.
   always_comb begin
      acc_cnt = '0;
      accept  = '0;
      for (int k = 0; k < WORD_M; k++) begin
         slot_ofs[k] = acc_cnt[PTR_W-1:0];
         wr_addr[k]  = wr_ptr_q[PTR_W-1:0] + acc_cnt[PTR_W-1:0];
         accept[k]   = !filter_on || (bank_word[k] < i_bound);
         if (accept[k]) begin
            acc_cnt = acc_cnt + COUNT_W'(1);
         end
      end
   end

   assign rej_cnt  = BANK_WORDS - acc_cnt;
   assign drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(rej_cnt);

   // Next-state for pointers and the saturating drop counter; flush clears the FIFO but keeps the drop count.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      drop_cnt_d = drop_cnt_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (cap) begin
            wr_ptr_d = wr_ptr_q + acc_cnt;
         end
         rd_ptr_d = rd_ptr_q + COUNT_W'(pop);
      end
      if (cap) begin
         drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end
   end

   // Control state: pointers and drop counter, cleared asynchronously.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // FIFO storage: up to WORD_M writes per capture edge, to distinct consecutive slots.
   always_ff @(posedge i_clk) begin
      if (cap) begin
         for (int k = 0; k < WORD_M; k++) begin
            if (accept[k]) begin
               mem_q[wr_addr[k]] <= bank_word[k];
            end
         end
      end
   end

   assign o_lfsr_enable = cap;
   assign o_valid       = (count != '0);
   assign o_data        = o_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;
   assign o_count       = count;
   assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rng_word_serializer.sv
// tb/tb_rng_word_serializer.sv - directed vector bench for rng_word_serializer with an attached 8-bit LFSR
module tb_rng_word_serializer;

   localparam int N  = 8;
   localparam int M  = 4;
   localparam int D  = 8;
   localparam int CW = 16;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b1;
   logic [M*N-1:0]  i_bank;
   logic            o_lfsr_enable;
   logic            i_bound_en = 1'b0;
   logic [N-1:0]    i_bound = '0;
   logic            i_flush = 1'b0;
   logic [N-1:0]    o_data;
   logic            o_valid;
   logic            i_ready = 1'b0;
   logic [3:0]      o_count;
   logic [CW-1:0]   o_drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   rng_word_serializer #(
      .WORD_N(N), .WORD_M(M), .FIFO_DEPTH(D), .CNT_W(CW)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_bank(i_bank), .o_lfsr_enable(o_lfsr_enable),
      .i_bound_en(i_bound_en), .i_bound(i_bound), .i_flush(i_flush),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_count(o_count), .o_drop_cnt(o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Attached parallel Fibonacci LFSR, P=8E, reset value C3 in every word.
   function automatic logic [M*N-1:0] next_bank(input logic [N-1:0] s);
      logic [N-1:0]   t;
      logic [M*N-1:0] nb;
      t  = s;
      nb = '0;
      for (int k = 0; k < M; k++) begin
         t = {t[N-2:0], ^(t & 8'h8E)};
         nb[k*N +: N] = t;
      end
      return nb;
   endfunction

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) i_bank <= {M{8'hC3}};
      else if (o_lfsr_enable) i_bank <= next_bank(i_bank[(M-1)*N +: N]);
   end

   typedef struct {
      bit         rst_first;
      logic       ready;
      logic       ben;
      logic [7:0] bound;
      logic       flush;
      logic       ev;
      logic [7:0] ed;
      logic [3:0] ec;
      logic       ee;
      logic [15:0] edr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rf, input logic rdy, input logic ben, input logic [7:0] bnd,
                      input logic fl, input logic ev, input logic [7:0] ed, input logic [3:0] ec,
                      input logic ee, input logic [15:0] edr);
      vec_t v;
      v.rst_first = rf; v.ready = rdy; v.ben = ben; v.bound = bnd; v.flush = fl;
      v.ev = ev; v.ed = ed; v.ec = ec; v.ee = ee; v.edr = edr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input int idx, input logic ev, input logic [7:0] ed,
                           input logic [3:0] ec, input logic ee, input logic [15:0] edr);
      chk({tag, ".valid"}, idx, 32'(o_valid), 32'(ev));
      chk({tag, ".data"},  idx, 32'(o_data), 32'(ed));
      chk({tag, ".count"}, idx, 32'(o_count), 32'(ec));
      chk({tag, ".en"},    idx, 32'(o_lfsr_enable), 32'(ee));
      chk({tag, ".drop"},  idx, 32'(o_drop_cnt), 32'(edr));
   endtask

   // Holds reset over two edges, checks the reset state, releases just after an edge.
   task automatic do_reset();
      i_rst = 1'b1; i_ready = 1'b0; i_bound_en = 1'b0; i_bound = '0; i_flush = 1'b0;
      @(posedge i_clk); @(posedge i_clk); #1;
      chk_outs("reset", 0, 1'b0, 8'h00, 4'd0, 1'b0, 16'd0);
      i_rst = 1'b0;
   endtask

   initial begin
      // rf rdy ben bound fl | valid data count en drop
      // Free-running stream, no filter.
      add(1, 1, 0, 8'h00, 0,  0, 8'h00, 0, 1, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 4, 1, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 7, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 6, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 5, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h86, 4, 1, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h0D, 7, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h1A, 6, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h34, 5, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h69, 4, 1, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hD3, 7, 0, 0);
      // Filtering, bound changes, flush keeps drop count.
      add(1, 0, 1, 8'h40, 0,  0, 8'h00, 0, 1, 0);
      add(0, 0, 1, 8'h40, 0,  0, 8'h00, 0, 1, 4);
      add(0, 0, 0, 8'h00, 0,  1, 8'h0D, 3, 1, 5);
      add(0, 0, 1, 8'h00, 0,  1, 8'h0D, 7, 0, 5);
      add(0, 1, 0, 8'h00, 0,  1, 8'h0D, 7, 0, 5);
      add(0, 1, 0, 8'h00, 0,  1, 8'h1A, 6, 0, 5);
      add(0, 1, 1, 8'h80, 0,  1, 8'h34, 5, 0, 5);
      add(0, 0, 1, 8'h80, 0,  1, 8'h69, 4, 1, 5);
      add(0, 0, 0, 8'h00, 1,  1, 8'h69, 6, 0, 7);
      add(0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 7);
      add(0, 0, 0, 8'h00, 0,  1, 8'hAD, 4, 1, 7);
      // Fill to full with frozen bank, drain, then flush at count 5.
      add(1, 0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 0);
      add(0, 0, 0, 8'h00, 0,  1, 8'hC3, 4, 1, 0);
      add(0, 0, 0, 8'h00, 0,  1, 8'hC3, 8, 0, 0);
      add(0, 0, 0, 8'h00, 0,  1, 8'hC3, 8, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 8, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 7, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 6, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'hC3, 5, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h86, 4, 1, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h0D, 7, 0, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h1A, 6, 0, 0);
      add(0, 1, 0, 8'h00, 1,  1, 8'h34, 5, 0, 0);
      add(0, 1, 0, 8'h00, 0,  0, 8'h00, 0, 1, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h9A, 4, 1, 0);
      add(0, 1, 0, 8'h00, 0,  1, 8'h35, 7, 0, 0);

      foreach (vecs[i]) begin
         if (vecs[i].rst_first) do_reset();
         i_ready    = vecs[i].ready;
         i_bound_en = vecs[i].ben;
         i_bound    = vecs[i].bound;
         i_flush    = vecs[i].flush;
         #1;
         chk_outs("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].ee, vecs[i].edr);
         @(posedge i_clk); #1;
      end

      // Asynchronous reset between edges with count 5 and drop 3.
      do_reset();
      @(posedge i_clk); #1;
      i_bound_en = 1'b1; i_bound = 8'h10;
      @(posedge i_clk); #1;
      i_bound_en = 1'b0;
      chk_outs("pre_arst", 0, 1'b1, 8'hC3, 4'd5, 1'b0, 16'd3);
      #2;
      i_rst = 1'b1;
      #1;
      chk_outs("arst", 0, 1'b0, 8'h00, 4'd0, 1'b0, 16'd0);
      @(posedge i_clk); #1;
      chk_outs("arst", 1, 1'b0, 8'h00, 4'd0, 1'b0, 16'd0);
      i_rst = 1'b0;
      #1;
      chk_outs("arst", 2, 1'b0, 8'h00, 4'd0, 1'b1, 16'd0);
      @(posedge i_clk); #1;
      chk_outs("arst", 3, 1'b1, 8'hC3, 4'd4, 1'b1, 16'd0);

      // Drop counter saturation: bound 1 rejects every nonzero LFSR word, 4 per edge.
      do_reset();
      i_bound_en = 1'b1; i_bound = 8'h01;
      repeat (16383) @(posedge i_clk);
      #1;
      chk_outs("sat", 0, 1'b0, 8'h00, 4'd0, 1'b1, 16'hFFFC);
      @(posedge i_clk); #1;
      chk_outs("sat", 1, 1'b0, 8'h00, 4'd0, 1'b1, 16'hFFFF);
      @(posedge i_clk); #1;
      chk_outs("sat", 2, 1'b0, 8'h00, 4'd0, 1'b1, 16'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
